// File: rtl/cache_miss_sequencer.sv
// cache_miss_sequencer
//   Miss-handling controller for a set-associative cache. On an accepted
//   lookup miss it latches the replacement victim way and invalidates it. If
//   the victim is dirty, it writes the line back over the bus. It then fetches
//   the new line beat by beat and finishes by validating the way and updating
//   the replacement state.
//
// Optional feature (compile-time macro CACHE_MISS_PERFCNT_EN):
//   adds 32-bit MissCount / WritebackCount performance counters.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   Miss             lookup missed (level, held until Stall drops)
//   FlushStage       cancels a miss that has not been accepted yet
//   VictimWay        one-hot victim way from the replacement policy
//   VictimDirty      dirty bit of the victim line
//   BusAck           bus accepts / returns one beat this cycle
//   BusReq           bus transaction active
//   BusWrite         1 = writeback beat, 0 = fetch beat
//   BusBeat          current beat index
//   LatchedWay       victim way held for the whole miss
//   LineWriteEn      write the fetched beat into LatchedWay at BusBeat
//   ClearValid       invalidate LatchedWay (1-cycle pulse)
//   SetValid         validate LatchedWay (1-cycle pulse)
//   LRUWriteEn       update replacement state (1-cycle pulse)
//   Stall            hold the pipeline
//   MissCount        accepted misses        (CACHE_MISS_PERFCNT_EN only)
//   WritebackCount   writebacks started     (CACHE_MISS_PERFCNT_EN only)
module cache_miss_sequencer #(
  parameter int NUMWAYS      = 4,
  parameter int BEATSPERLINE = 4,
  parameter int BEATLEN      = $clog2(BEATSPERLINE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Miss,
  input  logic               FlushStage,
  input  logic [NUMWAYS-1:0] VictimWay,
  input  logic               VictimDirty,
  input  logic               BusAck,
  output logic               BusReq,
  output logic               BusWrite,
  output logic [BEATLEN-1:0] BusBeat,
  output logic [NUMWAYS-1:0] LatchedWay,
  output logic               LineWriteEn,
  output logic               ClearValid,
  output logic               SetValid,
  output logic               LRUWriteEn,
  output logic               Stall
`ifdef CACHE_MISS_PERFCNT_EN
  ,
  output logic [31:0]        MissCount,
  output logic [31:0]        WritebackCount
`endif
);

  typedef enum logic [1:0] {IDLE, EVICT, FETCH, DONE} stateT;

  stateT               stateReg;
  logic [BEATLEN-1:0]  beatCountReg;
  logic [NUMWAYS-1:0]  latchedWayReg;
  logic                busReqReg;
  logic                busWriteReg;
  logic                clearValidReg;
  logic                setValidReg;
  logic                lruWriteEnReg;

  logic accept;
  logic lastBeat;

  assign accept   = Miss & ~FlushStage;
  assign lastBeat = (beatCountReg == BEATLEN'(BEATSPERLINE - 1));

  // Single FSM; every output except LineWriteEn/Stall is registered and set
  // on the transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg      <= IDLE;
      beatCountReg  <= '0;
      latchedWayReg <= '0;
      busReqReg     <= 1'b0;
      busWriteReg   <= 1'b0;
      clearValidReg <= 1'b0;
      setValidReg   <= 1'b0;
      lruWriteEnReg <= 1'b0;
    end else begin
      clearValidReg <= 1'b0;
      setValidReg   <= 1'b0;
      lruWriteEnReg <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (accept) begin
            latchedWayReg <= VictimWay;
            clearValidReg <= 1'b1;
            busReqReg     <= 1'b1;
            beatCountReg  <= '0;
            if (VictimDirty) begin
              stateReg    <= EVICT;
              busWriteReg <= 1'b1;
            end else begin
              stateReg    <= FETCH;
              busWriteReg <= 1'b0;
            end
          end
        end
        EVICT: begin
          if (BusAck) begin
            // Counter wraps to 0 on the last beat, ready for the fetch.
            beatCountReg <= beatCountReg + 1'b1;
            if (lastBeat) begin
              stateReg    <= FETCH;
              busWriteReg <= 1'b0;
            end
          end
        end
        FETCH: begin
          if (BusAck) begin
            beatCountReg <= beatCountReg + 1'b1;
            if (lastBeat) begin
              stateReg      <= DONE;
              busReqReg     <= 1'b0;
              setValidReg   <= 1'b1;
              lruWriteEnReg <= 1'b1;
            end
          end
        end
        DONE: begin
          stateReg <= IDLE;
        end
        default: begin
          stateReg <= IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_MISS_PERFCNT_EN
  logic [31:0] missCountReg;
  logic [31:0] writebackCountReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      missCountReg      <= '0;
      writebackCountReg <= '0;
    end else if (stateReg == IDLE && accept) begin
      missCountReg <= missCountReg + 32'd1;
      if (VictimDirty) begin
        writebackCountReg <= writebackCountReg + 32'd1;
      end
    end
  end

  assign MissCount      = missCountReg;
  assign WritebackCount = writebackCountReg;
`endif

  assign BusReq      = busReqReg;
  assign BusWrite    = busWriteReg;
  assign BusBeat     = beatCountReg;
  assign LatchedWay  = latchedWayReg;
  assign ClearValid  = clearValidReg;
  assign SetValid    = setValidReg;
  assign LRUWriteEn  = lruWriteEnReg;
  // The fetched beat is written in the same cycle the bus returns it.
  assign LineWriteEn = (stateReg == FETCH) & BusAck;
  // A miss stalls combinationally in its accept cycle; Stall drops the cycle
  // after DONE so the pipeline replays the access as a hit.
  assign Stall       = (stateReg != IDLE) | accept;

endmodule
